// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// State encoding, error codes and the default frame marker.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CHK   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one registered write port, one combinational read.
// Out-of-range indices are ignored on write and read back as zero.
module uart_frame_buf #(
  parameter int MAX_LEN = 8
) (
  input  logic       i_clock,
  input  logic       i_we,
  input  logic [7:0] i_widx,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_ridx,
  output logic [7:0] o_rdata
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [8:0] LIM = 9'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  // store one payload byte per accepted write
  always_ff @(posedge i_clock) begin
    if (i_we && ({1'b0, i_widx} < LIM))
      mem[i_widx[IW-1:0]] <= i_wdata;
  end

  assign o_rdata = ({1'b0, i_ridx} < LIM) ? mem[i_ridx[IW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser behind the UART byte receiver: SYNC ADDR LEN data CHK,
// then replays the checked payload as a burst of register writes.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 2048,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  input  logic       i_wr_ready,
  output logic       o_busy,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic [7:0] o_ok_cnt,
  output logic [7:0] o_err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0] LEN_LIM = 9'(MAX_LEN);

  state_t        state;
  logic [7:0]    addr;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    sum;
  logic [7:0]    k;
  logic [TW-1:0] tmo;

  logic       rx_state;
  logic       tmo_hit;
  logic       hs;
  logic       last;
  logic       frame_done;
  logic       buf_we;
  logic [7:0] rd_idx;
  logic [7:0] rd_data;
  logic       rej;
  logic [1:0] rej_code;

  assign rx_state   = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CHK);
  assign tmo_hit    = rx_state && !i_rx_dv && (tmo == TMO_LAST);
  assign hs         = o_wr_valid && i_wr_ready;
  assign last       = (k == len - 8'd1);
  assign frame_done = (state == S_DRAIN) && hs && last;
  assign buf_we     = (state == S_DATA) && i_rx_dv;
  assign rd_idx     = (state == S_DRAIN) ? k + 8'd1 : 8'd0;
  assign o_busy     = (state != S_IDLE);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .i_clock (i_clock),
    .i_we    (buf_we),
    .i_widx  (idx),
    .i_wdata (i_rx_byte),
    .i_ridx  (rd_idx),
    .o_rdata (rd_data)
  );

  // classify the reason a frame is rejected this cycle, if any
  always_comb begin
    rej      = 1'b0;
    rej_code = ERR_NONE;
    if (tmo_hit) begin
      rej      = 1'b1;
      rej_code = ERR_TMO;
    end else if (i_rx_dv && (state == S_LEN) &&
                 ((i_rx_byte == 8'd0) || ({1'b0, i_rx_byte} > LEN_LIM))) begin
      rej      = 1'b1;
      rej_code = ERR_LEN;
    end else if (i_rx_dv && (state == S_CHK) && (i_rx_byte != sum)) begin
      rej      = 1'b1;
      rej_code = ERR_CHK;
    end
  end

  // inter-byte timer, only runs while collecting a frame
  always_ff @(posedge i_clock) begin
    if (i_reset || !rx_state || i_rx_dv)
      tmo <= '0;
    else
      tmo <= tmo + TW'(1);
  end

  // frame parser and write-burst sequencer
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= S_IDLE;
      addr       <= 8'd0;
      len        <= 8'd0;
      idx        <= 8'd0;
      sum        <= 8'd0;
      k          <= 8'd0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= 8'd0;
      o_wr_data  <= 8'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_rx_dv && (i_rx_byte == SYNC_BYTE))
            state <= S_ADDR;
        end
        S_ADDR: begin
          if (rej) begin
            state <= S_IDLE;
          end else if (i_rx_dv) begin
            addr  <= i_rx_byte;
            sum   <= i_rx_byte;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (rej) begin
            state <= S_IDLE;
          end else if (i_rx_dv) begin
            len   <= i_rx_byte;
            idx   <= 8'd0;
            sum   <= sum + i_rx_byte;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rej) begin
            state <= S_IDLE;
          end else if (i_rx_dv) begin
            idx <= idx + 8'd1;
            sum <= sum + i_rx_byte;
            if (idx == len - 8'd1)
              state <= S_CHK;
          end
        end
        S_CHK: begin
          if (rej) begin
            state <= S_IDLE;
          end else if (i_rx_dv) begin
            k          <= 8'd0;
            o_wr_valid <= 1'b1;
            o_wr_addr  <= addr;
            o_wr_data  <= rd_data;
            state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hs) begin
            if (last) begin
              o_wr_valid <= 1'b0;
              state      <= S_IDLE;
            end else begin
              k         <= k + 8'd1;
              o_wr_addr <= o_wr_addr + 8'd1;
              o_wr_data <= rd_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // status pulses, last error code, overrun flag and frame counters
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_overrun   <= 1'b0;
      o_ok_cnt    <= 8'd0;
      o_err_cnt   <= 8'd0;
    end else begin
      o_frame_ok  <= frame_done;
      o_frame_err <= rej;
      if (rej) begin
        o_err_code <= rej_code;
        o_err_cnt  <= sat_inc(o_err_cnt);
      end
      if (frame_done)
        o_ok_cnt <= sat_inc(o_ok_cnt);
      if ((state == S_DRAIN) && i_rx_dv)
        o_overrun <= 1'b1;
    end
  end

endmodule
